// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: state width and the
// elaboration-time KMP failure/transition functions.
package seq_det_pkg;

  localparam int SD_MAX_PAT_LEN = 16;

  function automatic int sd_state_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // Pattern bit i counted from the first bit received (MSB of the pattern).
  function automatic logic sd_pat_bit(input logic [SD_MAX_PAT_LEN-1:0] pat,
                                      input int pat_len, input int i);
    logic [3:0] idx;
    idx = 4'(pat_len - 1 - i);
    return pat[idx];
  endfunction

  // Longest proper prefix of the whole pattern that is also its suffix.
  function automatic int sd_fail(input logic [SD_MAX_PAT_LEN-1:0] pat,
                                 input int pat_len);
    int  res;
    logic ok;
    res = 0;
    for (int k = 1; k < pat_len; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (sd_pat_bit(pat, pat_len, j) != sd_pat_bit(pat, pat_len, pat_len - k + j))
          ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

  // Longest pattern prefix that is a suffix of (first s pattern bits ++ b).
  function automatic int sd_delta(input logic [SD_MAX_PAT_LEN-1:0] pat,
                                  input int pat_len, input int s, input logic b);
    logic [SD_MAX_PAT_LEN:0] seq;
    int   res;
    logic ok;
    seq = '0;
    for (int j = 0; j < s; j++) seq[5'(j)] = sd_pat_bit(pat, pat_len, j);
    seq[5'(s)] = b;
    res = 0;
    for (int k = 1; k <= s + 1; k++) begin
      if (k <= pat_len) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (seq[5'(s + 1 - k + j)] != sd_pat_bit(pat, pat_len, j)) ok = 1'b0;
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_match_counter.sv
// Saturating match counter, +1 per inc, sync clear with priority, async reset.
// Count is registered: visible the cycle after inc/clear.
module seq_det_match_counter
  import seq_det_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                     cnt_d = '0;
    else if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/seq_detector_moore_param.sv
// Moore PAT_LEN-bit pattern spotter; out registered, high from the edge taking the last bit.
// in_valid=0 holds all state. Match counter present only with SEQ_DET_COUNT_EN.
module seq_detector_moore_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam int                    SW      = sd_state_w(PAT_LEN);
  localparam logic [SD_MAX_PAT_LEN-1:0] PAT16 = SD_MAX_PAT_LEN'(PATTERN);
  localparam int                    RESTART = OVERLAP ? sd_fail(PAT16, PAT_LEN) : 0;
  localparam logic [SW-1:0]         S_FULL  = SW'(PAT_LEN);

  if (PAT_LEN < 2 || PAT_LEN > SD_MAX_PAT_LEN) begin : g_bad_len
    $error("seq_detector_moore_param: PAT_LEN must be within 2..16");
  end

  // Full-match row restarts from the failure state (overlap) or from empty.
  logic [SW-1:0] delta_tbl [PAT_LEN+1][2];
  for (genvar s = 0; s <= PAT_LEN; s++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      localparam int NS = (s == PAT_LEN) ? sd_delta(PAT16, PAT_LEN, RESTART, (b == 1))
                                         : sd_delta(PAT16, PAT_LEN, s, (b == 1));
      assign delta_tbl[s][b] = SW'(NS);
    end
  end

  logic [SW-1:0] s_q, s_d;
  logic          out_q, out_d;

  always_comb begin
    s_d = s_q;
    if (in_valid) s_d = delta_tbl[s_q][in];
    out_d = (s_d == S_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q   <= '0;
      out_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef SEQ_DET_COUNT_EN
  seq_det_match_counter #(.W(CNT_W)) u_match_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (in_valid & out_d),
    .clear (clear),
    .count (match_count)
  );
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign match_count  = '0;
`endif

endmodule

// File: tb/tb_seq_detector_moore_param.sv
// Scoreboard bench for seq_detector_moore_param: four parameterisations share one stimulus
// stream; each directed segment queues hand-computed out/count values for the relevant instance.
module tb_seq_detector_moore_param;

  localparam int IA = 0;  // 1101, overlap
  localparam int IB = 1;  // 1101, no overlap
  localparam int IC = 2;  // 11, overlap
  localparam int ID = 3;  // 11, overlap, 2-bit counter

  logic clk = 1'b0;
  logic reset, ser_in, in_valid, clear;
  logic out_a, out_b, out_c, out_d;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;

  always #5 clk = ~clk;

  seq_detector_moore_param #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .in(ser_in), .in_valid(in_valid), .clear(clear),
    .out(out_a), .match_count(cnt_a));
  seq_detector_moore_param #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .in(ser_in), .in_valid(in_valid), .clear(clear),
    .out(out_b), .match_count(cnt_b));
  seq_detector_moore_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(8)) u_c (
    .clk(clk), .reset(reset), .in(ser_in), .in_valid(in_valid), .clear(clear),
    .out(out_c), .match_count(cnt_c));
  seq_detector_moore_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_d (
    .clk(clk), .reset(reset), .in(ser_in), .in_valid(in_valid), .clear(clear),
    .out(out_d), .match_count(cnt_d));

  typedef struct {
    int    cyc;
    int    inst;
    logic  exp_out;
    int    exp_cnt;
    string name;
  } exp_t;

  exp_t sb[$];
  int   edge_no = 0;
  int   checks  = 0;
  int   errors  = 0;

  always @(posedge clk) edge_no <= edge_no + 1;

  // Counter-less build ties match_count to zero.
  function automatic int exp_c(input int v);
`ifdef SEQ_DET_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic push(input int inst, input logic o, input int c, input string name);
    exp_t e;
    e.cyc = edge_no + 1; e.inst = inst; e.exp_out = o; e.exp_cnt = exp_c(c); e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic b, input logic v, input logic c);
    @(posedge clk);
    #2;
    reset = r; ser_in = b; in_valid = v; clear = c;
  endtask

  task automatic reset_all(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      push(IA, 1'b0, 0, "rst_a"); push(IB, 1'b0, 0, "rst_b");
      push(IC, 1'b0, 0, "rst_c"); push(ID, 1'b0, 0, "rst_d");
    end
  endtask

  // One bit per character; optional second instance checked on the same edges (ib < 0: none).
  task automatic feed(input string bits, input string vld, input string clr,
                      input int ia, input string eo_a, input string ec_a,
                      input int ib, input string eo_b, input string ec_b, input string name);
    for (int i = 0; i < bits.len(); i++) begin
      step(1'b0, bits[i] == "1", vld[i] == "1", clr[i] == "1");
      push(ia, eo_a[i] == "1", int'(ec_a[i]) - 48, $sformatf("%s_%0d", name, i + 1));
      if (ib >= 0)
        push(ib, eo_b[i] == "1", int'(ec_b[i]) - 48, $sformatf("%s_b_%0d", name, i + 1));
    end
  endtask

  // Monitor: compares every queued expectation on the edge it belongs to.
  initial begin
    exp_t e;
    logic ao;
    int   ac;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= edge_no) begin
        e = sb.pop_front();
        case (e.inst)
          IA:      begin ao = out_a; ac = int'(cnt_a); end
          IB:      begin ao = out_b; ac = int'(cnt_b); end
          IC:      begin ao = out_c; ac = int'(cnt_c); end
          default: begin ao = out_d; ac = int'(cnt_d); end
        endcase
        checks++;
        if (e.cyc != edge_no) begin
          errors++;
          $display("FAIL %s: checked at edge %0d, required edge %0d", e.name, edge_no, e.cyc);
        end
        if (ao !== e.exp_out) begin
          errors++;
          $display("FAIL %s out: got %b, expected %b", e.name, ao, e.exp_out);
        end
        checks++;
        if (ac != e.exp_cnt) begin
          errors++;
          $display("FAIL %s match_count: got %0d, expected %0d", e.name, ac, e.exp_cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ser_in = 1'b0; in_valid = 1'b0; clear = 1'b0;

    // Reset state, then reset mid-pattern after 110 must force a full 1101 again.
    reset_all(2);
    feed("110", "111", "000", IA, "000", "000", -1, "", "", "pre");
    reset_all(1);
    feed("1101", "1111", "0000", IA, "0001", "0001", -1, "", "", "post_rst");

    // 1101101: overlap fires after bits 4 and 7; non-overlap only after bit 4.
    reset_all(1);
    feed("1101101", "1111111", "0000000", IA, "0001001", "0001112",
         IB, "0001000", "0001111", "ovl");

    // Legacy 11 detector: 0111 holds out for two cycles, then a 0 drops it.
    reset_all(1);
    feed("01110", "11111", "00000", IC, "00110", "00122", -1, "", "", "p11");

    // 11, gap of five invalid cycles carrying 01010, then 01; out then holds while idle.
    reset_all(1);
    feed("11010100110", "11000001100", "00000000000", IA, "00000000111", "00000000111",
         -1, "", "", "gap");

    // 2-bit counter saturates at 3; clear on the fifth match edge wins; FSM unaffected.
    reset_all(1);
    feed("1111111", "1111111", "0000010", ID, "0111111", "0123301", -1, "", "", "sat");

    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
